async_fifo_gray: RTL and testbench

Dual-clock FIFO that moves DATA_WIDTH-bit words from a write clock domain to an independent read clock domain. It uses Gray-coded pointers with multi-stage synchronisers, registered full/empty and almost flags, and per-side occupancy counts. It keeps the per-access ack/err handshake of the existing single-domain FIFO, adds true clock-domain crossing and parametrised depth, and replaces the shift-register storage with a circular RAM. It sits between any two blocks running on unrelated clocks.

---
 rtl/async_fifo_gray.sv | 134 +++++++++++++
 tb/tb_async_fifo_gray.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO: circular RAM with Gray-coded pointers crossing through
// SYNC_STAGES-deep synchronisers; registered, pessimistic flags and counts per side.
module async_fifo_gray #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int AF_TH       = 1,
    parameter int AE_TH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  wr_clk,
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  almost_full,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic [ADDR_WIDTH:0]   wr_count,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [ADDR_WIDTH:0]   rd_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wbin, wgray, rbin, rgray;
    logic [PW-1:0] rgray_sync [SYNC_STAGES];
    logic [PW-1:0] wgray_sync [SYNC_STAGES];

    logic          wr_en, full_next, almost_full_next;
    logic [PW-1:0] wbin_next, wgray_next, rbin_at_wr, rgray_at_wr, wr_count_next;
    logic [PW:0]   free_next;

    logic          rd_en, empty_next, almost_empty_next;
    logic [PW-1:0] rbin_next, rgray_next, wbin_at_rd, rd_count_next;

    // Write side
    always_comb begin
        wr_en            = wr & ~full;
        wbin_next        = wbin + PW'(wr_en);
        wgray_next       = bin2gray(wbin_next);
        rgray_at_wr      = rgray_sync[SYNC_STAGES-1];
        rbin_at_wr       = gray2bin(rgray_at_wr);
        wr_count_next    = wbin_next - rbin_at_wr;
        // Full: write pointer is exactly one lap ahead of the synced read pointer.
        full_next        = (wgray_next == {~rgray_at_wr[PW-1:PW-2], rgray_at_wr[PW-3:0]});
        free_next        = (PW+1)'(DEPTH) - {1'b0, wr_count_next};
        almost_full_next = full_next || (free_next <= (PW+1)'(AF_TH));
    end

    always_ff @(posedge wr_clk) begin
        if (!rst_n) begin
            wbin        <= '0;
            wgray       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_ack      <= 1'b0;
            wr_err      <= 1'b0;
            wr_count    <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) rgray_sync[i] <= '0;
        end else begin
            rgray_sync[0] <= rgray;
            for (int i = 1; i < SYNC_STAGES; i++) rgray_sync[i] <= rgray_sync[i-1];
            wbin        <= wbin_next;
            wgray       <= wgray_next;
            full        <= full_next;
            almost_full <= almost_full_next;
            wr_ack      <= wr_en;
            wr_err      <= wr & full;
            wr_count    <= wr_count_next;
        end
    end

    // Storage is not reset; a write coinciding with reset is dropped.
    always_ff @(posedge wr_clk) begin
        if (rst_n && wr_en) mem[wbin[ADDR_WIDTH-1:0]] <= din;
    end

    // Read side
    always_comb begin
        rd_en             = rd & ~empty;
        rbin_next         = rbin + PW'(rd_en);
        rgray_next        = bin2gray(rbin_next);
        wbin_at_rd        = gray2bin(wgray_sync[SYNC_STAGES-1]);
        rd_count_next     = wbin_at_rd - rbin_next;
        empty_next        = (rgray_next == wgray_sync[SYNC_STAGES-1]);
        almost_empty_next = empty_next || (rd_count_next <= PW'(AE_TH));
    end

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            rbin         <= '0;
            rgray        <= '0;
            dout         <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_ack       <= 1'b0;
            rd_err       <= 1'b0;
            rd_count     <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) wgray_sync[i] <= '0;
        end else begin
            wgray_sync[0] <= wgray;
            for (int i = 1; i < SYNC_STAGES; i++) wgray_sync[i] <= wgray_sync[i-1];
            if (rd_en) dout <= mem[rbin[ADDR_WIDTH-1:0]];
            rbin         <= rbin_next;
            rgray        <= rgray_next;
            empty        <= empty_next;
            almost_empty <= almost_empty_next;
            rd_ack       <= rd_en;
            rd_err       <= rd & empty;
            rd_count     <= rd_count_next;
        end
    end

endmodule

// File: tb/tb_async_fifo_gray.sv
// Directed and scoreboarded bench for async_fifo_gray with default parameters
// (8-bit words, depth 8, thresholds 1, two synchroniser stages).
`timescale 1ns/1ps
module tb_async_fifo_gray;

    localparam int N = 1000;

    logic       wr_clk, rd_clk, rst_n, wr, rd;
    logic [7:0] din, dout;
    logic       full, almost_full, wr_ack, wr_err;
    logic       empty, almost_empty, rd_ack, rd_err;
    logic [3:0] wr_count, rd_count;

    realtime wr_half = 5.0;
    realtime rd_half = 13.5;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q[$];
    int  sent, nread, wcyc, rcyc, lat;
    logic wr_drv, rd_drv, full_seen, empty_seen;
    logic [7:0] exp_word;

    async_fifo_gray dut (
        .wr_clk(wr_clk), .rd_clk(rd_clk), .rst_n(rst_n),
        .wr(wr), .din(din), .full(full), .almost_full(almost_full),
        .wr_ack(wr_ack), .wr_err(wr_err), .wr_count(wr_count),
        .rd(rd), .dout(dout), .empty(empty), .almost_empty(almost_empty),
        .rd_ack(rd_ack), .rd_err(rd_err), .rd_count(rd_count)
    );

    // Read clock starts off a fractional phase so its edges never coincide with wr_clk edges.
    initial begin wr_clk = 0; forever #(wr_half) wr_clk = ~wr_clk; end
    initial begin rd_clk = 0; #1.3; forever #(rd_half) rd_clk = ~rd_clk; end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_word(input logic [7:0] d);
        @(negedge wr_clk); wr = 1'b1; din = d;
        @(posedge wr_clk); #1; wr = 1'b0;
    endtask

    task automatic read_word();
        @(negedge rd_clk); rd = 1'b1;
        @(posedge rd_clk); #1; rd = 1'b0;
    endtask

    initial begin
        rst_n = 0; wr = 0; rd = 0; din = 0;
        repeat (6) @(posedge rd_clk);
        @(negedge wr_clk); rst_n = 1;
        repeat (2) @(posedge rd_clk); #1;
        check("rst_full", 32'(full), 0);
        check("rst_af", 32'(almost_full), 0);
        check("rst_wr_count", 32'(wr_count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_ae", 32'(almost_empty), 1);
        check("rst_rd_count", 32'(rd_count), 0);

        // Read while empty
        read_word();
        check("e_rd_err", 32'(rd_err), 1);
        check("e_rd_ack", 32'(rd_ack), 0);
        check("e_empty", 32'(empty), 1);
        check("e_ae", 32'(almost_empty), 1);
        check("e_dout", 32'(dout), 0);

        // Fill with 0x01..0x08, then one write too many
        @(negedge wr_clk); wr = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            din = 8'(i);
            @(posedge wr_clk); #1;
            if (i <= 8) begin
                check("fill_ack", 32'(wr_ack), 1);
                check("fill_err", 32'(wr_err), 0);
                check("fill_count", 32'(wr_count), 32'(i));
            end
            if (i == 6) check("fill6_af", 32'(almost_full), 0);
            if (i == 7) begin
                check("fill7_af", 32'(almost_full), 1);
                check("fill7_full", 32'(full), 0);
            end
            if (i == 8) check("fill8_full", 32'(full), 1);
            if (i == 9) begin
                check("ovf_err", 32'(wr_err), 1);
                check("ovf_ack", 32'(wr_ack), 0);
                check("ovf_full", 32'(full), 1);
                check("ovf_count", 32'(wr_count), 8);
            end
            @(negedge wr_clk);
        end
        wr = 1'b0;

        for (int k = 0; k < 20 && rd_count != 4'd8; k++) begin @(posedge rd_clk); #1; end
        check("pre_drain_rd_count", 32'(rd_count), 8);

        // Drain all 8 back-to-back, then one read too many
        @(negedge rd_clk); rd = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge rd_clk); #1;
            if (i <= 8) begin
                check("drain_ack", 32'(rd_ack), 1);
                check("drain_dout", 32'(dout), 32'(i));
                check("drain_count", 32'(rd_count), 32'(8 - i));
            end
            if (i == 6) check("drain6_ae", 32'(almost_empty), 0);
            if (i == 7) begin
                check("drain7_ae", 32'(almost_empty), 1);
                check("drain7_empty", 32'(empty), 0);
            end
            if (i == 8) check("drain8_empty", 32'(empty), 1);
            if (i == 9) begin
                check("udf_err", 32'(rd_err), 1);
                check("udf_ack", 32'(rd_ack), 0);
                check("udf_dout", 32'(dout), 8);
            end
        end
        rd = 1'b0;

        for (int k = 0; k < 20 && (full || wr_count != 0); k++) begin @(posedge wr_clk); #1; end
        check("freed_full", 32'(full), 0);
        check("freed_af", 32'(almost_full), 0);
        check("freed_count", 32'(wr_count), 0);

        // Write-to-empty latency
        repeat (10) @(posedge rd_clk);
        @(negedge wr_clk); wr = 1'b1; din = 8'h33;
        @(posedge wr_clk);
        fork begin @(negedge wr_clk); wr = 1'b0; end join_none
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(posedge rd_clk); #1;
            if (!empty) lat = k;
        end
        check("lat_edges", 32'(lat), 3);
        check("lat_ae", 32'(almost_empty), 1);
        check("lat_count", 32'(rd_count), 1);
        write_word(8'h34);
        for (int k = 0; k < 20 && rd_count != 4'd2; k++) begin @(posedge rd_clk); #1; end
        check("two_count", 32'(rd_count), 2);
        check("two_ae", 32'(almost_empty), 0);
        read_word();
        check("lat_rd1", 32'(dout), 32'h33);
        read_word();
        check("lat_rd2", 32'(dout), 32'h34);
        check("lat_rd2_ack", 32'(rd_ack), 1);
        check("lat_empty", 32'(empty), 1);

        // Random stream: 3:1 then 1:3 clock ratio
        wr_half = 5.0; rd_half = 15.0;
        sent = 0; nread = 0; wcyc = 0; rcyc = 0;
        fork
            begin
                while (sent < N && wcyc < 20000) begin
                    @(negedge wr_clk);
                    wr_drv = ($urandom_range(0, 3) != 0);
                    wr = wr_drv; din = 8'($urandom); full_seen = full;
                    @(posedge wr_clk); #1;
                    check("s_wr_ack", 32'(wr_ack), 32'(wr_drv && !full_seen));
                    check("s_wr_err", 32'(wr_err), 32'(wr_drv && full_seen));
                    if (wr_ack) begin
                        q.push_back(din);
                        sent++;
                        if (sent == N / 2) begin wr_half = 15.0; rd_half = 5.0; end
                    end
                    wr = 1'b0;
                    wcyc++;
                end
                wr = 1'b0;
            end
            begin
                while (nread < N && rcyc < 30000) begin
                    @(negedge rd_clk);
                    rd_drv = ($urandom_range(0, 3) != 0);
                    rd = rd_drv; empty_seen = empty;
                    @(posedge rd_clk); #1;
                    check("s_rd_ack", 32'(rd_ack), 32'(rd_drv && !empty_seen));
                    check("s_rd_err", 32'(rd_err), 32'(rd_drv && empty_seen));
                    if (rd_ack) begin
                        if (q.size() == 0) check("s_sb_empty", 1, 0);
                        else begin
                            exp_word = q.pop_front();
                            check("s_dout", 32'(dout), 32'(exp_word));
                        end
                        nread++;
                    end
                    rd = 1'b0;
                    rcyc++;
                end
                rd = 1'b0;
            end
        join
        check("s_sent", 32'(sent), N);
        check("s_read", 32'(nread), N);
        check("s_wraps_ge_50", 32'(sent / 16 >= 50), 1);
        check("s_sb_left", 32'(q.size()), 0);

        // Reset with 5 words stored; in-flight accesses during reset are dropped
        wr_half = 5.0; rd_half = 13.5;
        for (int i = 0; i < 5; i++) write_word(8'(8'h50 + i));
        for (int k = 0; k < 20 && rd_count != 4'd5; k++) begin @(posedge rd_clk); #1; end
        check("pre_rst_count", 32'(rd_count), 5);
        @(negedge wr_clk); rst_n = 0; wr = 1'b1; din = 8'hEE; rd = 1'b1;
        repeat (6) @(posedge rd_clk); #1;
        check("mrst_empty", 32'(empty), 1);
        check("mrst_ae", 32'(almost_empty), 1);
        check("mrst_rd_count", 32'(rd_count), 0);
        check("mrst_dout", 32'(dout), 0);
        check("mrst_rd_ack", 32'(rd_ack), 0);
        check("mrst_rd_err", 32'(rd_err), 0);
        check("mrst_full", 32'(full), 0);
        check("mrst_af", 32'(almost_full), 0);
        check("mrst_wr_count", 32'(wr_count), 0);
        check("mrst_wr_ack", 32'(wr_ack), 0);
        check("mrst_wr_err", 32'(wr_err), 0);
        @(negedge wr_clk); rst_n = 1; wr = 1'b0; rd = 1'b0;
        repeat (6) @(posedge rd_clk); #1;
        check("post_rst_empty", 32'(empty), 1);
        check("post_rst_count", 32'(rd_count), 0);
        write_word(8'hA5);
        for (int k = 0; k < 20 && empty; k++) begin @(posedge rd_clk); #1; end
        check("a5_visible", 32'(empty), 0);
        check("a5_count", 32'(rd_count), 1);
        read_word();
        check("a5_ack", 32'(rd_ack), 1);
        check("a5_dout", 32'(dout), 32'hA5);
        check("a5_empty", 32'(empty), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
